program_loader: RTL

Upstream boot stage for the single-cycle MIPS core. Accepts a byte stream over a valid/ready handshake and decodes address and instruction commands. Drives the core's instruction-memory write port (`instruction_Write_en`, `Write_address`, `Write_instruction`) and holds the core in reset while loading. On command, releases the core into execution for a fixed reset pulse and can later halt it again for reload.

---
 rtl/program_loader_if.sv | 52 +++++
 rtl/program_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Bundles the loader's byte-stream input and the signals it drives towards
// the MIPS core.
//   in_valid / in_data / in_ready   byte stream (valid/ready handshake)
//   instruction_Write_en            one-cycle instruction-memory write strobe
//   Write_address                   word address being written (32 bits)
//   Write_instruction               instruction word being written
//   core_reset / running            core control and status
//   error                           sticky illegal-command flag
//   words_loaded                    saturating count of words written
// The slave modport is the loader's side. The master modport is the stream
// source, which also observes the outputs.
// ---------------------------------------------------------------------------
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        instruction_Write_en;
    logic [31:0] Write_address;
    logic [31:0] Write_instruction;
    logic        core_reset;
    logic        running;
    logic        error;
    logic [15:0] words_loaded;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output instruction_Write_en,
        output Write_address,
        output Write_instruction,
        output core_reset,
        output running,
        output error,
        output words_loaded
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  instruction_Write_en,
        input  Write_address,
        input  Write_instruction,
        input  core_reset,
        input  running,
        input  error,
        input  words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot stage for the single-cycle MIPS core. It decodes a byte stream of
// SET_ADDR / WRITE / RUN / HALT commands, writes instruction words into the
// core's instruction memory, and holds the core in reset while loading.
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   bus     program_loader_if.slave (byte stream in, write port and status out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_CMD     | waiting for a command byte (core held in reset)
// S_ADDR_HI | SET_ADDR: expecting address high byte
// S_ADDR_LO | SET_ADDR: expecting address low byte
// S_D0..D3  | WRITE: expecting instruction bytes, MSB first
// S_WR      | one-cycle write strobe; address increments on exit
// S_RST     | core_reset pulse after RUN, RESET_CYCLES long
// S_RUN     | core executing; only HALT is accepted as legal
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W       = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    program_loader_if.slave     bus
);

    localparam logic [7:0] CMD_SET_ADDR = 8'hA5;
    localparam logic [7:0] CMD_WRITE    = 8'h5A;
    localparam logic [7:0] CMD_RUN      = 8'h0F;
    localparam logic [7:0] CMD_HALT     = 8'hF0;

    // Counter holds RESET_CYCLES-1 down to 0.
    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_D0,
        S_D1,
        S_D2,
        S_D3,
        S_WR,
        S_RST,
        S_RUN
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         addr_hi_q;
    logic [23:0]        data_q;
    logic [31:0]        instr_q;
    logic               we_q;
    logic               core_reset_q;
    logic               running_q;
    logic               error_q;
    logic [15:0]        words_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_ready_c;
    logic               xfer;
    logic [ADDR_W-1:0]  addr_load_d;
    logic [ADDR_W-1:0]  addr_inc_d;

    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_CMD, S_ADDR_HI, S_ADDR_LO,
            S_D0, S_D1, S_D2, S_D3, S_RUN: in_ready_c = 1'b1;
            default:                       in_ready_c = 1'b0;
        endcase
        if (reset) begin
            in_ready_c = 1'b0;
        end
    end

    assign xfer = bus.in_valid && in_ready_c;

    // Received 16-bit address is zero-extended or truncated to ADDR_W.
    assign addr_load_d = ADDR_W'({addr_hi_q, bus.in_data});
    // Wraps modulo 2^ADDR_W.
    assign addr_inc_d  = addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CMD;
            addr_q       <= '0;
            addr_hi_q    <= '0;
            data_q       <= '0;
            instr_q      <= '0;
            we_q         <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
            cnt_q        <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_CMD: begin
                    if (xfer) begin
                        case (bus.in_data)
                            CMD_SET_ADDR: state_q <= S_ADDR_HI;
                            CMD_WRITE:    state_q <= S_D0;
                            CMD_RUN: begin
                                state_q <= S_RST;
                                cnt_q   <= CNT_W'(RESET_CYCLES - 1);
                            end
                            // HALT is only meaningful while running.
                            default:      error_q <= 1'b1;
                        endcase
                    end
                end
                S_ADDR_HI: begin
                    if (xfer) begin
                        addr_hi_q <= bus.in_data;
                        state_q   <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (xfer) begin
                        addr_q  <= addr_load_d;
                        state_q <= S_CMD;
                    end
                end
                S_D0: begin
                    if (xfer) begin
                        data_q[23:16] <= bus.in_data;
                        state_q       <= S_D1;
                    end
                end
                S_D1: begin
                    if (xfer) begin
                        data_q[15:8] <= bus.in_data;
                        state_q      <= S_D2;
                    end
                end
                S_D2: begin
                    if (xfer) begin
                        data_q[7:0] <= bus.in_data;
                        state_q     <= S_D3;
                    end
                end
                S_D3: begin
                    // Instruction register only changes here, so it holds
                    // its last value outside the write cycle.
                    if (xfer) begin
                        instr_q <= {data_q, bus.in_data};
                        we_q    <= 1'b1;
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    addr_q  <= addr_inc_d;
                    if (words_q != 16'hFFFF) begin
                        words_q <= words_q + 16'd1;
                    end
                    state_q <= S_CMD;
                end
                S_RST: begin
                    if (cnt_q == '0) begin
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                        state_q      <= S_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (bus.in_data == CMD_HALT) begin
                            core_reset_q <= 1'b1;
                            running_q    <= 1'b0;
                            state_q      <= S_CMD;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_CMD;
            endcase
        end
    end

    assign bus.in_ready             = in_ready_c;
    assign bus.instruction_Write_en = we_q;
    assign bus.Write_address        = 32'(addr_q);
    assign bus.Write_instruction    = instr_q;
    assign bus.core_reset           = core_reset_q;
    assign bus.running              = running_q;
    assign bus.error                = error_q;
    assign bus.words_loaded         = words_q;

endmodule
